// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_ctrl_pkg
// Desc     : Shared opcode/func constants, ALU codes, FSM state and mux encodings
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SUBU = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1101;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

    localparam logic [1:0] DEST_RT = 2'd0;
    localparam logic [1:0] DEST_RD = 2'd1;
    localparam logic [1:0] DEST_RA = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_JR      = 4'd2,
        CLS_IALU    = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_BNE     = 4'd7,
        CLS_J       = 4'd8,
        CLS_JAL     = 4'd9
    } iclass_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decode
// Desc     : Maps opcode/func to instruction class, 4-bit ALU op and illegal flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output iclass_t    iclass,
    output logic       illegal
);

    always_comb begin
        alu_op = ALU_NOP;
        iclass = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                iclass = CLS_RTYPE;
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_ADDU: alu_op = ALU_ADDU;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SUBU: alu_op = ALU_SUBU;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_JR:   iclass = CLS_JR;
                    default: iclass = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin iclass = CLS_IALU; alu_op = ALU_ADD;  end
            OP_ADDIU: begin iclass = CLS_IALU; alu_op = ALU_ADDU; end
            OP_ANDI:  begin iclass = CLS_IALU; alu_op = ALU_AND;  end
            OP_ORI:   begin iclass = CLS_IALU; alu_op = ALU_OR;   end
            OP_SLTI:  begin iclass = CLS_IALU; alu_op = ALU_SLT;  end
            OP_SLTIU: begin iclass = CLS_IALU; alu_op = ALU_SLTU; end
            OP_LUI:   begin iclass = CLS_IALU; alu_op = ALU_LUI;  end
            OP_LW:    begin iclass = CLS_LW;   alu_op = ALU_ADD;  end
            OP_SW:    begin iclass = CLS_SW;   alu_op = ALU_ADD;  end
            OP_BEQ:   begin iclass = CLS_BEQ;  alu_op = ALU_SUB;  end
            OP_BNE:   begin iclass = CLS_BNE;  alu_op = ALU_SUB;  end
            OP_J:     iclass = CLS_J;
            OP_JAL:   iclass = CLS_JAL;
            default:  iclass = CLS_ILLEGAL;
        endcase
        illegal = (iclass == CLS_ILLEGAL);
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Desc     : Multi-cycle MIPS control unit (IDLE/FETCH/DECODE/EXEC/MEM/WB)
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         reg_dest,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic [3:0]       w_alu_op4;
    logic [3:0]       w_dec_op;
    iclass_t          w_cls;
    logic             w_dec_illegal;

    alu_op_decode u_dec (
        .opcode  (opcode),
        .func    (func),
        .alu_op  (w_dec_op),
        .iclass  (w_cls),
        .illegal (w_dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_alu_op4  = ALU_NOP;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = DEST_RT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        illegal    = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                w_alu_op4 = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // ALUOut <= PC + (imm << 2): branch target ready for EXEC
                alu_src_b = SRCB_IMMSH2;
                w_alu_op4 = ALU_ADD;
                if (w_dec_illegal) begin
                    illegal = 1'b1;
                    w_next  = ST_FETCH;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_alu_op4 = w_dec_op;
                case (w_cls)
                    CLS_RTYPE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_RT;
                        w_next    = ST_WB;
                    end
                    CLS_IALU: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        w_next    = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        w_next    = ST_MEM;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_RT;
                        pc_src    = PCSRC_BRANCH;
                        pc_write  = (w_cls == CLS_BEQ) ? zero : !zero;
                        w_next    = ST_FETCH;
                        w_retire  = 1'b1;
                    end
                    CLS_J, CLS_JAL: begin
                        // jal links the already-incremented PC into r31
                        pc_write  = 1'b1;
                        pc_src    = PCSRC_JUMP;
                        reg_write = (w_cls == CLS_JAL);
                        reg_dest  = (w_cls == CLS_JAL) ? DEST_RA : DEST_RT;
                        w_next    = ST_FETCH;
                        w_retire  = 1'b1;
                    end
                    CLS_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_RS;
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                iord      = 1'b1;
                mem_read  = (w_cls == CLS_LW);
                mem_write = (w_cls != CLS_LW);
                if (mem_ready) begin
                    if (w_cls == CLS_LW) begin
                        w_next = ST_WB;
                    end else begin
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dest   = (w_cls == CLS_RTYPE) ? DEST_RD : DEST_RT;
                mem_to_reg = (w_cls == CLS_LW);
                w_next     = ST_FETCH;
                w_retire   = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign alu_op  = ALUOP_W'(w_alu_op4);
    assign retired = r_retired;

endmodule
`default_nettype wire
